// File: rtl/pipeline_pkg.sv
// Shared definitions for the issue controller: field positions, opcode
// groups, instruction classes and the scoreboard slot layout.
package pipeline_pkg;

    localparam int unsigned WINDOW_DEFAULT = 3;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RD_MSB = 25;
    localparam int unsigned RD_LSB = 21;
    localparam int unsigned RS_MSB = 20;
    localparam int unsigned RS_LSB = 16;
    localparam int unsigned RT_MSB = 15;
    localparam int unsigned RT_LSB = 11;

    localparam logic [2:0] GRP_ITYPE = 3'b011;
    localparam logic [2:0] GRP_RTYPE = 3'b010;
    localparam logic [5:0] OP_UNARY  = 6'b010001;

    typedef enum logic [1:0] {
        CLS_ILLEGAL,
        CLS_ITYPE,
        CLS_RUNARY,
        CLS_RBINARY
    } instr_class_e;

    typedef struct packed {
        logic       busy;
        logic [4:0] rd;
    } sb_entry_t;

    function automatic instr_class_e classify(input logic [5:0] op);
        instr_class_e c;
        if (op[5:3] == GRP_ITYPE)      c = CLS_ITYPE;
        else if (op == OP_UNARY)       c = CLS_RUNARY;
        else if (op[5:3] == GRP_RTYPE) c = CLS_RBINARY;
        else                           c = CLS_ILLEGAL;
        return c;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Two-entry synchronous FIFO; push and pop may happen in the same cycle,
// a pushed word only becomes visible at the head from the next cycle on.
module issue_fifo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign dout    = mem[rd_ptr];

    // Storage write; data words need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/pipeline_issue_ctrl.sv
// In-order issue controller: buffers fetched instructions, blocks a head
// that reads a register still in flight, and drives registered issue slots.
module pipeline_issue_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned WINDOW = WINDOW_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrIn,
    input  logic        InstrValid,
    output logic        InstrReady,
    output logic [31:0] InstrOut,
    output logic        WriteEnable,
    output logic [15:0] StallCount,
    output logic [15:0] IssueCount
);

    logic [31:0]  head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         hazard;
    logic         head_legal;
    logic         reads_rs;
    logic         reads_rt;
    instr_class_e head_cls;
    logic [4:0]   head_rd;
    logic [4:0]   head_rs;
    logic [4:0]   head_rt;
    sb_entry_t    sb [WINDOW];

    assign InstrReady = !fifo_full && !rst;
    assign push       = InstrValid && InstrReady;
    assign pop        = !fifo_empty && !hazard;

    issue_fifo #(
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (InstrIn),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Decode the head and compare its source registers with in-flight writers.
    always_comb begin
        head_cls   = classify(head[OP_MSB:OP_LSB]);
        head_rd    = head[RD_MSB:RD_LSB];
        head_rs    = head[RS_MSB:RS_LSB];
        head_rt    = head[RT_MSB:RT_LSB];
        head_legal = (head_cls != CLS_ILLEGAL);
        reads_rs   = head_legal;
        reads_rt   = (head_cls == CLS_RBINARY);
        hazard     = 1'b0;
        for (int unsigned i = 0; i < WINDOW; i++) begin
            if (sb[i].busy && ((reads_rs && sb[i].rd == head_rs) ||
                               (reads_rt && sb[i].rd == head_rt))) begin
                hazard = 1'b1;
            end
        end
        if (fifo_empty) begin
            hazard = 1'b0;
        end
    end

    // Scoreboard shift register: slot 0 records this cycle's legal writer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < WINDOW; i++) begin
                sb[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < WINDOW; i++) begin
                sb[i] <= sb[i-1];
            end
            if (pop && head_legal) begin
                sb[0] <= '{busy: 1'b1, rd: head_rd};
            end else begin
                sb[0] <= '0;
            end
        end
    end

    // Registered issue slot plus saturating issue/stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            InstrOut    <= NOP;
            WriteEnable <= 1'b0;
            StallCount  <= '0;
            IssueCount  <= '0;
        end else if (pop) begin
            InstrOut    <= head;
            WriteEnable <= head_legal;
            if (head_legal && IssueCount != '1) begin
                IssueCount <= IssueCount + 16'd1;
            end
        end else begin
            InstrOut    <= NOP;
            WriteEnable <= 1'b0;
            if (hazard && StallCount != '1) begin
                StallCount <= StallCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Bench for pipeline_issue_ctrl: directed vector table, randomized run
// against a queue-based reference model, and a counter saturation run on
// a second instance with a wide window.
module tb_pipeline_issue_ctrl;

    localparam int W = 3;
    localparam int SAT_W = 32;
    localparam int SAT_EDGES = 70000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic        write_enable;
    logic [15:0] stall_count;
    logic [15:0] issue_count;

    logic        s_rst;
    logic [31:0] s_instr_in;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_out;
    logic        s_we;
    logic [15:0] s_stall;
    logic [15:0] s_issue;
    logic        sat_done = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_issue_ctrl #(.WINDOW(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .InstrIn     (instr_in),
        .InstrValid  (instr_valid),
        .InstrReady  (instr_ready),
        .InstrOut    (instr_out),
        .WriteEnable (write_enable),
        .StallCount  (stall_count),
        .IssueCount  (issue_count)
    );

    pipeline_issue_ctrl #(.WINDOW(SAT_W)) sat_dut (
        .clk         (clk),
        .rst         (s_rst),
        .InstrIn     (s_instr_in),
        .InstrValid  (s_valid),
        .InstrReady  (s_ready),
        .InstrOut    (s_out),
        .WriteEnable (s_we),
        .StallCount  (s_stall),
        .IssueCount  (s_issue)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction-level view) ----------------
    logic [31:0] m_q[$];
    int          m_hist[$];       // destination written per recent issue slot, -1 = none
    logic [31:0] m_out;
    logic        m_we;
    int          m_stall;
    int          m_issue;

    function automatic void ref_decode(input logic [31:0] ins, output bit legal,
                                       output int ra, output int rb, output int wr);
        logic [5:0] op;
        op = ins[31:26];
        wr = int'(ins[25:21]);
        ra = -1;
        rb = -1;
        legal = 1'b1;
        if (op >= 6'o30 && op <= 6'o37) ra = int'(ins[20:16]);           // I-type
        else if (op == 6'o21) ra = int'(ins[20:16]);                      // unary R
        else if (op >= 6'o20 && op <= 6'o27) begin                        // binary R
            ra = int'(ins[20:16]);
            rb = int'(ins[15:11]);
        end else begin
            legal = 1'b0;
            wr = -1;
        end
    endfunction

    function automatic bit ref_ready(input logic r);
        return !r && (m_q.size() < 2);
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [31:0] ins);
        bit acc, legal, haz;
        int ra, rb, wr, rec;
        acc = v && ref_ready(r);
        if (r) begin
            m_q.delete();
            m_hist.delete();
            for (int i = 0; i < W; i++) m_hist.push_back(-1);
            m_out = '0; m_we = 1'b0; m_stall = 0; m_issue = 0;
            return;
        end
        rec = -1;
        m_out = '0;
        m_we  = 1'b0;
        if (m_q.size() > 0) begin
            ref_decode(m_q[0], legal, ra, rb, wr);
            haz = 1'b0;
            foreach (m_hist[k]) if (m_hist[k] >= 0 && (m_hist[k] == ra || m_hist[k] == rb)) haz = 1'b1;
            if (haz) begin
                if (m_stall < 65535) m_stall++;
            end else begin
                m_out = m_q.pop_front();
                m_we  = legal;
                if (legal) begin
                    rec = wr;
                    if (m_issue < 65535) m_issue++;
                end
            end
        end
        if (acc) m_q.push_back(ins);
        m_hist.push_front(rec);
        void'(m_hist.pop_back());
    endtask

    // ---------------- one clock cycle on the main instance ----------------
    logic ready_seen;

    task automatic do_cycle(input logic r, input logic v, input logic [31:0] ins);
        rst = r;
        instr_valid = v;
        instr_in = ins;
        #2;
        ready_seen = instr_ready;
        @(posedge clk);
        #1;
        model_step(r, v, ins);
    endtask

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] ins;
        logic        ready;
        logic [31:0] out;
        logic        we;
        logic [15:0] stall;
        logic [15:0] issue;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic v, logic [31:0] ins, logic rdy,
                                logic [31:0] out, logic we, int st, int is);
        vec_t x;
        x.r = r; x.v = v; x.ins = ins; x.ready = rdy;
        x.out = out; x.we = we; x.stall = 16'(st); x.issue = 16'(is);
        return x;
    endfunction

    localparam logic [31:0] P = 32'h6822_0005;  // addi r1 <- r2
    localparam logic [31:0] C = 32'h4901_1000;  // add  r8 <- r1, r2
    localparam logic [31:0] D = 32'h6864_0000;  // addi r3 <- r4
    localparam logic [31:0] E = 32'h68A6_0000;  // addi r5 <- r6
    localparam logic [31:0] F = 32'h6920_0000;  // addi r9 <- r0

    // ---------------- main test ----------------
    initial begin
        logic [31:0] ins;
        logic [5:0]  op;
        logic        v, r;
        bit          done;
        rst = 1'b1; instr_valid = 1'b0; instr_in = '0;
        @(posedge clk);
        #1;

        // independent stream
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h6800_0005, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h6822_000A, 1, 32'h6800_0005, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h6822_000A, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 2));
        // RAW: exactly three bubbles
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, P, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, C, 1, P, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 1));
        vecs.push_back(mk(0, 0, 0, 1, C, 1, 3, 2));
        // backpressure during a hazard
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, P, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, C, 1, P, 1, 0, 1));
        vecs.push_back(mk(0, 1, D, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, E, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 1, E, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, 1, E, 0, C, 1, 3, 2));
        vecs.push_back(mk(0, 1, E, 1, D, 1, 3, 3));
        vecs.push_back(mk(0, 0, 0, 1, E, 1, 3, 4));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 4));
        // illegal opcode neither stalls its follower nor counts
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hFC20_0000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h4841_0800, 1, 32'hFC20_0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h4841_0800, 1, 0, 1));
        // r0 is an ordinary register
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h6800_0005, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h6820_0000, 1, 32'h6800_0005, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h6820_0000, 1, 3, 2));
        // reset with FIFO full and a stall pending
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, P, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, C, 1, P, 1, 0, 1));
        vecs.push_back(mk(0, 1, D, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, E, 0, 0, 0, 2, 1));
        vecs.push_back(mk(1, 1, E, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, F, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, F, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));

        foreach (vecs[n]) begin
            do_cycle(vecs[n].r, vecs[n].v, vecs[n].ins);
            check($sformatf("vec%0d ready", n), {31'b0, ready_seen}, {31'b0, vecs[n].ready});
            check($sformatf("vec%0d out", n), instr_out, vecs[n].out);
            check($sformatf("vec%0d we", n), {31'b0, write_enable}, {31'b0, vecs[n].we});
            check($sformatf("vec%0d stall", n), {16'b0, stall_count}, {16'b0, vecs[n].stall});
            check($sformatf("vec%0d issue", n), {16'b0, issue_count}, {16'b0, vecs[n].issue});
        end

        // randomized run against the reference model
        do_cycle(1'b1, 1'b0, '0);
        for (int n = 0; n < 1500; n++) begin
            bit exp_rdy;
            case ($urandom_range(0, 3))
                0: op = {3'b011, 3'($urandom_range(0, 7))};
                1: op = 6'b010001;
                2: op = {3'b010, 3'($urandom_range(0, 7))};
                default: op = 6'($urandom_range(0, 63));
            endcase
            ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 11'($urandom_range(0, 2047))};
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 99) == 0);
            exp_rdy = ref_ready(r);
            do_cycle(r, v, ins);
            check("rand ready", {31'b0, ready_seen}, {31'b0, exp_rdy});
            check("rand out", instr_out, m_out);
            check("rand we", {31'b0, write_enable}, {31'b0, m_we});
            check("rand stall", {16'b0, stall_count}, 32'(m_stall));
            check("rand issue", {16'b0, issue_count}, 32'(m_issue));
        end
        instr_valid = 1'b0;

        done = 1'b0;
        for (int n = 0; n < 100000 && !done; n++) begin
            @(posedge clk);
            done = sat_done;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL sat_timeout: got not-done expected done");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Saturation run: a chain of addi r1 <- r1 on a 32-deep window gives one
    // issue followed by 32 stalls, repeating every 33 edges.
    initial begin
        int exp_issue, exp_stall;
        s_rst = 1'b1; s_valid = 1'b0; s_instr_in = 32'h6821_0000;
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        s_valid = 1'b1;
        repeat (SAT_EDGES) @(posedge clk);
        #1;
        exp_issue = (SAT_EDGES - 2) / 33 + 1;
        exp_stall = SAT_EDGES - 1 - exp_issue;
        if (exp_stall > 65535) exp_stall = 65535;
        check("sat stall", {16'b0, s_stall}, 32'(exp_stall));
        check("sat issue", {16'b0, s_issue}, 32'(exp_issue));
        s_valid = 1'b0;
        sat_done = 1'b1;
    end

endmodule
